// File: rtl/int_prio_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : int_prio_ctrl                                                     |
// | Brief   : N-channel prioritised, vectored interrupt controller. Per-channel |
// |           edge capture, mask, fixed priority (ch0 highest), vector output.  |
// |           Define INT_NEST_EN to let a higher-priority request preempt the   |
// |           running handler, up to DEPTH levels.                              |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module int_prio_ctrl #(
  parameter int               N_CH       = 4,
  parameter int               VEC_W      = 8,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(8'hF0),
  parameter int               VEC_STRIDE = 2,
  parameter int               DEPTH      = 4
) (
  input  logic                       t3,
  input  logic                       clr,
  input  logic [N_CH-1:0]            irq,
  input  logic                       ei,
  input  logic                       di,
  input  logic                       mask_wr,
  input  logic [N_CH-1:0]            mask_din,
  input  logic                       int_ack,
  input  logic                       iret,
  output logic                       int_req,
  output logic [VEC_W-1:0]           int_vec,
  output logic                       en_int,
  output logic [N_CH-1:0]            pending,
  output logic [N_CH-1:0]            in_service,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err
);

  localparam int c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int c_DW   = $clog2(DEPTH + 1);
`ifdef INT_NEST_EN
  localparam int c_DEPTH_MAX = DEPTH;
`else
  localparam int c_DEPTH_MAX = 1;
`endif
  localparam logic [c_DW-1:0] c_LIMIT = c_DW'(c_DEPTH_MAX);

  logic [N_CH-1:0]   r_irq_q;
  logic [N_CH-1:0]   r_pending;
  logic [N_CH-1:0]   r_mask;
  logic [N_CH-1:0]   r_in_service;
  logic [c_DW-1:0]   r_depth;
  logic              r_en_int;
  logic [VEC_W-1:0]  r_int_vec;
  logic              r_err;

  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   w_eligible;
  logic [c_CH_W-1:0] w_best;
  logic [c_CH_W-1:0] w_cur;
  logic              w_cur_vld;
  logic              w_gate;
  logic              w_req;
  logic              w_accept;
  logic [VEC_W-1:0]  w_best_vec;

  logic [N_CH-1:0]   w_pending_nxt;
  logic [N_CH-1:0]   w_in_service_nxt;
  logic [c_DW-1:0]   w_depth_nxt;
  logic              w_en_int_nxt;
  logic [VEC_W-1:0]  w_int_vec_nxt;
  logic              w_err_nxt;

  assign w_rise     = irq & ~r_irq_q;
  assign w_eligible = r_pending & ~r_mask;
  assign w_cur_vld  = |r_in_service;

  // Lowest index wins: scan from the top so the last hit is the highest priority.
  always_comb begin
    w_best = '0;
    w_cur  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_eligible[i])   w_best = c_CH_W'(i);
      if (r_in_service[i]) w_cur  = c_CH_W'(i);
    end
  end

`ifdef INT_NEST_EN
  assign w_gate = (r_depth < c_LIMIT) && (!w_cur_vld || (w_best < w_cur));
`else
  assign w_gate = (r_depth == '0);
`endif

  assign w_req      = r_en_int & (|w_eligible) & w_gate;
  assign w_accept   = int_ack & w_req & ~iret;
  assign w_best_vec = VEC_BASE + VEC_W'(int'(w_best) * VEC_STRIDE);

  always_comb begin
    w_pending_nxt    = r_pending;
    w_in_service_nxt = r_in_service;
    w_depth_nxt      = r_depth;
    w_en_int_nxt     = r_en_int;
    w_int_vec_nxt    = r_int_vec;
    w_err_nxt        = r_err;

    if (di)      w_en_int_nxt = 1'b0;
    else if (ei) w_en_int_nxt = 1'b1;

    if (iret) begin
      w_en_int_nxt = 1'b1;
      if (r_depth == '0) begin
        w_err_nxt = 1'b1;
      end else begin
        w_in_service_nxt[w_cur] = 1'b0;
        w_depth_nxt             = r_depth - c_DW'(1);
      end
    end else if (w_accept) begin
      w_pending_nxt[w_best]    = 1'b0;
      w_in_service_nxt[w_best] = 1'b1;
      w_depth_nxt              = r_depth + c_DW'(1);
      w_int_vec_nxt            = w_best_vec;
      w_en_int_nxt             = 1'b0;
    end else if (int_ack && (r_depth == c_LIMIT)) begin
      w_err_nxt = 1'b1;
    end

    // A fresh rise on the channel just accepted must survive the clear.
    w_pending_nxt = w_pending_nxt | w_rise;
  end

  always_ff @(negedge t3) begin
    if (!clr) begin
      r_irq_q      <= '0;
      r_pending    <= '0;
      r_mask       <= '0;
      r_in_service <= '0;
      r_depth      <= '0;
      r_en_int     <= 1'b1;
      r_int_vec    <= VEC_BASE;
      r_err        <= 1'b0;
    end else begin
      r_irq_q      <= irq;
      r_pending    <= w_pending_nxt;
      if (mask_wr) r_mask <= mask_din;
      r_in_service <= w_in_service_nxt;
      r_depth      <= w_depth_nxt;
      r_en_int     <= w_en_int_nxt;
      r_int_vec    <= w_int_vec_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign int_req    = w_req;
  assign int_vec    = r_int_vec;
  assign en_int     = r_en_int;
  assign pending    = r_pending;
  assign in_service = r_in_service;
  assign depth      = r_depth;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_int_prio_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_int_prio_ctrl                                                  |
// | Brief   : scoreboard bench for int_prio_ctrl; honours INT_NEST_EN.          |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module tb_int_prio_ctrl;

  localparam int c_N   = 4;
  localparam int c_VW  = 8;
  localparam int c_DW  = 3;

  localparam int S_REQ = 0, S_VEC = 1, S_EN = 2, S_PEND = 3, S_INS = 4, S_DEP = 5, S_ERR = 6;

  logic            t3 = 1'b1;
  logic            clr, ei, di, mask_wr, int_ack, iret;
  logic [c_N-1:0]  irq, mask_din;
  logic            int_req, en_int, err;
  logic [c_VW-1:0] int_vec;
  logic [c_N-1:0]  pending, in_service;
  logic [c_DW-1:0] depth;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int_prio_ctrl #(
    .N_CH(4), .VEC_W(8), .VEC_BASE(8'hF0), .VEC_STRIDE(2), .DEPTH(4)
  ) u_dut (
    .t3(t3), .clr(clr), .irq(irq), .ei(ei), .di(di),
    .mask_wr(mask_wr), .mask_din(mask_din), .int_ack(int_ack), .iret(iret),
    .int_req(int_req), .int_vec(int_vec), .en_int(en_int), .pending(pending),
    .in_service(in_service), .depth(depth), .err(err)
  );

  always #5 t3 = ~t3;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_REQ:   return 32'(int_req);
      S_VEC:   return 32'(int_vec);
      S_EN:    return 32'(en_int);
      S_PEND:  return 32'(pending);
      S_INS:   return 32'(in_service);
      S_DEP:   return 32'(depth);
      default: return 32'(err);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  // Falling edge updates state; outputs are compared on the following rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge t3);
    @(posedge t3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
    int_ack = 0; iret = 0; ei = 0; di = 0; mask_wr = 0;
  endtask

  task automatic expect_reset(input string tag);
    expect_val({tag, "_req"},  S_REQ,  0);
    expect_val({tag, "_vec"},  S_VEC,  32'hF0);
    expect_val({tag, "_en"},   S_EN,   1);
    expect_val({tag, "_pend"}, S_PEND, 0);
    expect_val({tag, "_ins"},  S_INS,  0);
    expect_val({tag, "_dep"},  S_DEP,  0);
    expect_val({tag, "_err"},  S_ERR,  0);
  endtask

  initial begin
    clr = 0; irq = 0; ei = 0; di = 0; mask_wr = 0; mask_din = 0; int_ack = 0; iret = 0;
    cycle();
    expect_reset("rst");
    cycle();
    clr = 1;

    // single request on ch2
    irq = 4'b0100;
    expect_val("t1_pend", S_PEND, 4'b0100); expect_val("t1_req", S_REQ, 1);
    cycle();
    int_ack = 1;
    expect_val("t1_vec", S_VEC, 32'hF4); expect_val("t1_ins", S_INS, 4'b0100);
    expect_val("t1_pend0", S_PEND, 0);   expect_val("t1_en", S_EN, 0);
    expect_val("t1_dep", S_DEP, 1);      expect_val("t1_req0", S_REQ, 0);
    cycle();
    iret = 1;
    expect_val("t1_iret_ins", S_INS, 0); expect_val("t1_iret_dep", S_DEP, 0);
    expect_val("t1_iret_en", S_EN, 1);
    cycle();
    irq = 0;
    cycle();

    // simultaneous rises on ch1 and ch3
    irq = 4'b1010;
    expect_val("t2_pend", S_PEND, 4'b1010); expect_val("t2_req", S_REQ, 1);
    cycle();
    int_ack = 1;
    expect_val("t2_vec1", S_VEC, 32'hF2); expect_val("t2_ins1", S_INS, 4'b0010);
    expect_val("t2_pend1", S_PEND, 4'b1000); expect_val("t2_req_busy", S_REQ, 0);
    cycle();
    iret = 1;
    expect_val("t2_req_after_iret", S_REQ, 1);
    cycle();
    int_ack = 1;
    expect_val("t2_vec3", S_VEC, 32'hF6); expect_val("t2_ins3", S_INS, 4'b1000);
    expect_val("t2_pend3", S_PEND, 0);
    cycle();

    // ch3 in service, higher-priority ch0 arrives after EI
    ei = 1;
    expect_val("t3_en", S_EN, 1);
    cycle();
    irq = 4'b1011;
    expect_val("t3_pend", S_PEND, 4'b0001);
`ifdef INT_NEST_EN
    expect_val("t3_req_nest", S_REQ, 1);
    cycle();
    int_ack = 1;
    expect_val("t3_vec", S_VEC, 32'hF0); expect_val("t3_dep2", S_DEP, 2);
    expect_val("t3_ins2", S_INS, 4'b1001);
    cycle();
    iret = 1;
    expect_val("t3_iret_ins", S_INS, 4'b1000); expect_val("t3_iret_dep", S_DEP, 1);
    cycle();
    iret = 1;
    expect_val("t3_iret2_ins", S_INS, 0);
    cycle();
`else
    expect_val("t3_req_flat", S_REQ, 0);
    cycle();
    int_ack = 1;
    expect_val("t3_noack_vec", S_VEC, 32'hF6); expect_val("t3_noack_pend", S_PEND, 4'b0001);
    expect_val("t3_noack_dep", S_DEP, 1);
    cycle();
    iret = 1;
    expect_val("t3_iret_ins", S_INS, 0); expect_val("t3_iret_req", S_REQ, 1);
    cycle();
    int_ack = 1;
    expect_val("t3_vec", S_VEC, 32'hF0); expect_val("t3_ins0", S_INS, 4'b0001);
    cycle();
    iret = 1;
    expect_val("t3_iret2_ins", S_INS, 0);
    cycle();
`endif
    irq = 0;
    expect_val("t3_dep0", S_DEP, 0);
    cycle();

    // masking keeps the pending bit but blocks the request
    mask_wr = 1; mask_din = 4'b0001;
    cycle();
    irq = 4'b0001;
    expect_val("t4_pend", S_PEND, 4'b0001); expect_val("t4_req_masked", S_REQ, 0);
    cycle();
    mask_wr = 1; mask_din = 4'b0000;
    expect_val("t4_req_unmasked", S_REQ, 1);
    cycle();
    int_ack = 1;
    expect_val("t4_vec", S_VEC, 32'hF0);
    cycle();
    iret = 1; irq = 0;
    cycle();

    // iret at depth 0, then di beats ei
    iret = 1;
    expect_val("t5_err", S_ERR, 1); expect_val("t5_en", S_EN, 1); expect_val("t5_dep", S_DEP, 0);
    cycle();
    di = 1; ei = 1;
    expect_val("t5_di_wins", S_EN, 0); expect_val("t5_err_sticky", S_ERR, 1);
    cycle();
    ei = 1;
    expect_val("t5_ei", S_EN, 1);
    cycle();

    // rise on the channel being accepted keeps it pending; iret beats ack
    irq = 4'b0100;
    cycle();
    irq = 4'b0000;
    cycle();
    irq = 4'b0100; int_ack = 1;
    expect_val("p_pend_kept", S_PEND, 4'b0100); expect_val("p_ins", S_INS, 4'b0100);
    expect_val("p_dep", S_DEP, 1);
    cycle();
    iret = 1; int_ack = 1;
    expect_val("p_iret_ins", S_INS, 0);    expect_val("p_iret_dep", S_DEP, 0);
    expect_val("p_iret_pend", S_PEND, 4'b0100); expect_val("p_iret_en", S_EN, 1);
    cycle();

    // clr in the middle of a handler with requests pending
    int_ack = 1;
    expect_val("t6_ins", S_INS, 4'b0100);
    cycle();
    ei = 1; irq = 4'b0111;
    expect_val("t6_pend", S_PEND, 4'b0011);
    cycle();
`ifdef INT_NEST_EN
    int_ack = 1;
    expect_val("t6_dep2", S_DEP, 2);
    cycle();
`endif
    clr = 0; irq = 4'b1111; int_ack = 1; ei = 1; iret = 0; mask_wr = 1; mask_din = 4'b1111;
    expect_reset("t6_clr");
    cycle();
    clr = 1;
    expect_val("t6_post_pend", S_PEND, 4'b1111); expect_val("t6_post_req", S_REQ, 1);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
